// File: rtl/dm_resp_if.sv
// ============================================================================
//  Module : dm_resp_if
//  Brief  : Request/response bus between the core's data-access path and
//           the dm_resp memory responder.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dm_resp_if #(
    parameter int ADDR_W = 12
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic [31:0]       rdata;
    logic              err;
    logic              busy;

    modport master (
        output req, we, size, sext, addr, wdata,
        input  ready, rdata, err, busy
    );

    modport slave (
        input  req, we, size, sext, addr, wdata,
        output ready, rdata, err, busy
    );
endinterface

`default_nettype wire

// File: rtl/dm_resp.sv
// ============================================================================
//  Module : dm_resp
//  Brief  : Single-outstanding data-memory responder with WAIT_CYC wait
//           states, byte-lane store merging and sign/zero-extended loads
//           from a word-organised little-endian RAM.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_resp #(
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 2
) (
    input  wire logic clk,
    input  wire logic rst,      // asynchronous, active-low
    dm_resp_if.slave  bus
);

    localparam int         C_DEPTH    = 2 ** (ADDR_W - 2);
    localparam logic [3:0] C_CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;

    logic              r_we;
    logic [1:0]        r_size;
    logic              r_sext;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic              r_err;
    logic [31:0]       r_rdata;

    logic [31:0]       r_mem [C_DEPTH];

    logic              w_accept;
    logic              w_commit;
    logic              w_we;
    logic [1:0]        w_size;
    logic              w_sext;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic              w_err;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [3:0]        w_be;
    logic [31:0]       w_wpat;
    logic [31:0]       w_merged;

    assign w_accept = (r_state == S_IDLE) && bus.req;

    // Commit happens on the edge that enters RESP. With no wait states that
    // is the accept edge itself; holding rst low suppresses it entirely.
    assign w_commit = rst && (((WAIT_CYC == 0) && w_accept) ||
                              ((r_state == S_WAIT) && (r_cnt == 4'd0)));

    // On the accept edge the latches are not yet loaded, so take the live bus.
    assign w_we    = (r_state == S_IDLE) ? bus.we    : r_we;
    assign w_size  = (r_state == S_IDLE) ? bus.size  : r_size;
    assign w_sext  = (r_state == S_IDLE) ? bus.sext  : r_sext;
    assign w_addr  = (r_state == S_IDLE) ? bus.addr  : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? bus.wdata : r_wdata;

    assign w_word  = r_mem[w_addr[ADDR_W-1:2]];
    assign w_byte  = w_word[{w_addr[1:0], 3'b000} +: 8];
    assign w_half  = w_word[{w_addr[1], 4'b0000} +: 16];

    // Alignment check, lane enables, replicated store pattern, load extension
    always_comb begin
        w_err  = 1'b0;
        w_be   = 4'b1111;
        w_wpat = w_wdata;
        w_load = w_word;
        case (w_size)
            2'b00: begin
                w_be   = 4'b0001 << w_addr[1:0];
                w_wpat = {4{w_wdata[7:0]}};
                w_load = {{24{w_sext & w_byte[7]}}, w_byte};
            end
            2'b01: begin
                w_err  = w_addr[0];
                w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wpat = {2{w_wdata[15:0]}};
                w_load = {{16{w_sext & w_half[15]}}, w_half};
            end
            2'b10: begin
                w_err  = (w_addr[1:0] != 2'b00);
            end
            default: begin
                w_err  = 1'b1;
            end
        endcase
    end

    // Byte-lane merge: selected lanes take the store pattern, others keep RAM
    always_comb begin
        w_merged = w_word;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                w_merged[8*i +: 8] = w_wpat[8*i +: 8];
            end
        end
    end

    // FSM state and wait counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM next state: IDLE -> WAIT -> RESP -> IDLE, WAIT skipped for zero waits
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    w_cnt_nxt   = C_CNT_INIT;
                    w_state_nxt = (WAIT_CYC == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture the request attributes on the accept edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_sext  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_we    <= bus.we;
            r_size  <= bus.size;
            r_sext  <= bus.sext;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
        end
    end

    // Register the response on the commit edge; stores and errors return zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else if (w_commit) begin
            r_err   <= w_err;
            r_rdata <= (w_err || w_we) ? 32'd0 : w_load;
        end
    end

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_commit && w_we && !w_err) begin
            r_mem[w_addr[ADDR_W-1:2]] <= w_merged;
        end
    end

    assign bus.ready = (r_state == S_RESP);
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.rdata = r_rdata;
    assign bus.err   = r_err;

endmodule

`default_nettype wire
